// File: rtl/fib_pkg.sv
// Shared constants and state encoding for the Fibonacci generator and index finder.
`timescale 1ns/1ps
package fib_pkg;
  localparam int unsigned FIB_W       = 32;
  localparam int unsigned FIB_MAX_IDX = 47;
  localparam logic [FIB_W-1:0] FIB_MAX_VAL = 32'd2971215073;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fib_state_e;
endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: next_b = a + b computed 33 bits wide, carry is bit 32.
`timescale 1ns/1ps
module fib_step
  import fib_pkg::*;
(
  input  logic [FIB_W-1:0] a,
  input  logic [FIB_W-1:0] b,
  output logic [FIB_W-1:0] next_b,
  output logic             carry
);
  logic [FIB_W:0] sum_s;

  // widened sum so the overflow out of the top term is visible
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    next_b = sum_s[FIB_W-1:0];
    carry  = sum_s[FIB_W];
  end
endmodule

// File: rtl/fib_index_finder.sv
// Start/done coprocessor returning the largest n with F(n) <= value, one term per clock.
`timescale 1ns/1ps
module fib_index_finder
  import fib_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] index,
  output logic [31:0]      fib,
  output logic             is_fib
);
  localparam logic [WIDTH-1:0] K_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] K_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  fib_state_e       state_r;
  logic [FIB_W-1:0] val_r;
  logic [FIB_W-1:0] a_r;
  logic [FIB_W-1:0] b_r;
  logic [WIDTH-1:0] k_r;
  logic [FIB_W-1:0] next_b_s;
  logic             carry_s;

  fib_step u_step (
    .a      (a_r),
    .b      (b_r),
    .next_b (next_b_s),
    .carry  (carry_s)
  );

  // search FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      val_r   <= 32'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      k_r     <= K_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
      index   <= K_ZERO;
      fib     <= 32'd0;
      is_fib  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            val_r   <= value;
            a_r     <= 32'd0;
            b_r     <= 32'd1;
            k_r     <= K_ONE;
            busy    <= 1'b1;
            state_r <= SEARCH;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SEARCH: begin
          if (b_r == val_r) begin
            index   <= k_r;
            fib     <= b_r;
            is_fib  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (b_r > val_r) begin
            // overshoot: previous term is the answer; only value 0 lands here exactly
            index   <= k_r - K_ONE;
            fib     <= a_r;
            is_fib  <= (val_r == 32'd0);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (carry_s) begin
            // next term would not fit: saturate at F(47)
            index   <= k_r;
            fib     <= b_r;
            is_fib  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            a_r <= b_r;
            b_r <= next_b_s;
            k_r <= k_r + K_ONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/fib_index_finder.md
# fib_index_finder

Sequential inverse of the combinational Fibonacci generator. Given a 32-bit value, it iterates the Fibonacci recurrence one term per clock. It returns the largest index n with F(n) ≤ value, the matching term F(n), and a flag saying whether the value is itself a Fibonacci number. It sits beside the generator as a start/done coprocessor, and benches use it to cross-check generator outputs.

## Interface
- WIDTH, 8, index width; must be ≥ 6, because the largest 32-bit Fibonacci index is 47.

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy == 0
- value  input  32  operand, captured on an accepted start
- busy  output  1  high while searching
- done  output  1  one-cycle pulse when results update
- index  output  WIDTH  largest n with F(n) ≤ value
- fib  output  32  F(index)
- is_fib  output  1  value == F(index)

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE/DONE, start = 1:
  - capture value into val_q;
  - load a = 0, b = 1, k = 1;
  - go to SEARCH.
- IDLE, start = 0: stay in IDLE.
- DONE, start = 0: go to IDLE.
- SEARCH, one compare per cycle (b = F(k), a = F(k-1)), checked in this priority order:
  - b == val_q: index = k, fib = b, is_fib = 1, go to DONE.
  - b > val_q: index = k-1, fib = a, is_fib = (val_q == 0), go to DONE. This covers value 0 → index 0, fib 0, is_fib 1.
  - b < val_q and a + b carries out of 32 bits: index = k, fib = b, is_fib = 0, go to DONE. This is saturation at F(47) = 2971215073.
  - Otherwise: a ← b, b ← a + b, k ← k + 1.
- The sum is computed 33 bits wide; bit 32 is the carry.
- F(1) = F(2) = 1, so value 1 reports index 1 (the smallest index).
- start is ignored while busy = 1; a search cannot be aborted except by reset.
- index, fib and is_fib update only in the cycle done rises, and then hold until the next done.
- busy = 1 exactly in SEARCH.
- done = 1 exactly in DONE.
- Reset, including mid-search:
  - state goes to IDLE;
  - busy, done, index, fib and is_fib all go to 0;
  - a, b, k and val_q are cleared;
  - no done pulse is emitted for an aborted search.

## Timing
- start accepted on edge T: busy is high from T+1.
- The search terminates on the compare at k = j (during cycle T+j). done and the results appear at T+j+1 for one cycle.
- Latencies, start to done:
  - value 0 or 1: 2 cycles.
  - value = F(n), n ≥ 3: n+1 cycles.
  - non-Fibonacci value v with F(m) < v < F(m+1): m+2 cycles.
  - saturation (v > F(47)): 48 cycles. This is the worst case.
- Back-to-back operation: start asserted during the DONE cycle is accepted, so throughput is one result per (latency + 0) cycles with no idle bubble.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package fib_pkg:
  - FIB_W = 32;
  - FIB_MAX_IDX = 47;
  - FIB_MAX_VAL = 32'd2971215073;
  - state enum {IDLE, SEARCH, DONE}.
- The generator module shares the same package constants.
- Sub-module fib_step: combinational 33-bit adder producing next_b and carry from (a, b). It is the only arithmetic and keeps the FSM file control-only.
- Expected size: about 150–250 lines total.

## Test plan
- value 0, then value 1 (back-to-back starts in DONE) → both done after 2 cycles. Results: index 0, fib 0, is_fib 1; then index 1, fib 1, is_fib 1.
- value 144 → done 13 cycles after start; index 12, fib 144, is_fib 1.
- value 100 → index 11, fib 89, is_fib 0, done after 13 cycles. Also check value 2 → index 3, fib 2, is_fib 1.
- value 32'hFFFFFFFF → done after 48 cycles; index 47, fib 2971215073, is_fib 0. Also check value 2971215073 → index 47, is_fib 1.
- start pulses with value 5 while busy during a value-1000 search → ignored. Result: index 16, fib 987, is_fib 0; exactly one done pulse.
- rst_n low for 1 cycle mid-search of value 4181 → all outputs 0 immediately and no done pulse. A new start with value 8 then yields index 6, fib 8, is_fib 1.
